// File: rtl/video_timing_pkg.sv
// Shared types for the video timing recovery block: lock FSM states and the
// default-width frame geometry record.
package video_timing_pkg;

    localparam int DEF_CNT_W = 10;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_VERIFY  = 2'd2,
        ST_LOCKED  = 2'd3
    } state_e;

    typedef struct packed {
        logic [DEF_CNT_W-1:0] h_total;
        logic [DEF_CNT_W-1:0] h_visible;
        logic [DEF_CNT_W-1:0] v_total;
        logic [DEF_CNT_W-1:0] v_visible;
    } geom_t;

endpackage

// File: rtl/video_timing_recovery_sync_edge_detect.sv
// Registers one sync input, folds its polarity to active-high and flags the
// 0->1 transition between consecutive samples.
module sync_edge_detect #(
    parameter bit ACTIVE_HIGH = 1'b1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_sync,
    output logic o_rise
);
    // Reset to the inactive raw level so an active-low input does not fake an edge.
    localparam logic IDLE_RAW = !ACTIVE_HIGH;

    logic raw_q;
    logic prev_q;
    logic lvl;

    assign lvl    = ACTIVE_HIGH ? raw_q : ~raw_q;
    assign o_rise = lvl & ~prev_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            raw_q  <= IDLE_RAW;
            prev_q <= 1'b0;
        end else begin
            raw_q  <= i_sync;
            prev_q <= lvl;
        end
    end

endmodule

// File: rtl/video_timing_recovery.sv
// Recovers pixel position from hsync/vsync/visible strobes, measures line and
// frame geometry, and reports lock once two consecutive frames measure alike.
module video_timing_recovery
    import video_timing_pkg::*;
#(
    parameter int CNT_W            = DEF_CNT_W,
    parameter bit SYNC_ACTIVE_HIGH = 1'b1,
    parameter int TIMEOUT          = 1023
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_hsync,
    input  logic             i_vsync,
    input  logic             i_visible,
    output logic [CNT_W-1:0] o_hpos,
    output logic [CNT_W-1:0] o_vpos,
    output logic             o_visible,
    output logic             o_frame_start,
    output logic [CNT_W-1:0] o_h_total,
    output logic [CNT_W-1:0] o_h_visible,
    output logic [CNT_W-1:0] o_v_total,
    output logic [CNT_W-1:0] o_v_visible,
    output logic             o_locked
);
    typedef struct packed {
        logic [CNT_W-1:0] h_total;
        logic [CNT_W-1:0] h_visible;
        logic [CNT_W-1:0] v_total;
        logic [CNT_W-1:0] v_visible;
    } meas_t;

    localparam logic [CNT_W-1:0] CMAX = '1;
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] TMO  = CNT_W'(TIMEOUT);

    logic hs_rise, vs_rise;

    sync_edge_detect #(.ACTIVE_HIGH(SYNC_ACTIVE_HIGH)) u_hs_edge (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_sync (i_hsync),
        .o_rise (hs_rise)
    );

    sync_edge_detect #(.ACTIVE_HIGH(SYNC_ACTIVE_HIGH)) u_vs_edge (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_sync (i_vsync),
        .o_rise (vs_rise)
    );

    logic             vis_q, vis_o_q;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] hpos_q, hpos_d;
    logic [CNT_W-1:0] vpos_q, vpos_d;
    logic             first_q, first_d;
    logic             fs_q;
    meas_t            acc_q, acc_n, acc_d;
    logic             hset_q, hset_n, hset_d;
    logic             vset_q, vset_n, vset_d;
    logic             ok_q, ok_n, ok_d;
    meas_t            lat_q, lat_d;
    state_e           state_q, state_d;
    logic             locked_q, locked_d;

    logic             run_start, run_end, timeout, match;
    logic [CNT_W-1:0] period;

    assign run_start = vis_q & ~vis_o_q;
    assign run_end   = ~vis_q & vis_o_q;
    assign period    = h_cnt_q + ONE;
    assign timeout   = (h_cnt_q == TMO);

    always_comb begin
        h_cnt_d = h_cnt_q;
        if (hs_rise)
            h_cnt_d = '0;
        else if (!timeout)
            h_cnt_d = h_cnt_q + ONE;

        run_d  = '0;
        hpos_d = '0;
        if (vis_q) begin
            run_d  = run_start ? ONE : ((run_q == CMAX) ? run_q : run_q + ONE);
            hpos_d = run_start ? '0 : hpos_q + ONE;
        end

        first_d = first_q | vs_rise;
        vpos_d  = vpos_q;
        if (run_start) begin
            vpos_d  = first_d ? '0 : vpos_q + ONE;
            first_d = 1'b0;
        end

        // acc_n is the ending frame including this sample's hsync/run events,
        // so a coincident vsync edge sees them before bookkeeping.
        acc_n  = acc_q;
        hset_n = hset_q;
        vset_n = vset_q;
        ok_n   = ok_q;
        if (hs_rise) begin
            if (h_cnt_q == CMAX) ok_n = 1'b0;
            if (!hset_q) begin
                acc_n.h_total = period;
                hset_n        = 1'b1;
            end else if (period != acc_q.h_total) begin
                ok_n = 1'b0;
            end
            if (acc_q.v_total >= CMAX - ONE) ok_n = 1'b0;
            if (acc_q.v_total != CMAX) acc_n.v_total = acc_q.v_total + ONE;
        end
        if (run_end) begin
            if (run_q == CMAX) ok_n = 1'b0;
            if (!vset_q) begin
                acc_n.h_visible = run_q;
                vset_n          = 1'b1;
            end else if (run_q != acc_q.h_visible) begin
                ok_n = 1'b0;
            end
            if (acc_q.v_visible >= CMAX - ONE) ok_n = 1'b0;
            if (acc_q.v_visible != CMAX) acc_n.v_visible = acc_q.v_visible + ONE;
        end
        match = (acc_n == lat_q);

        acc_d  = acc_n;
        hset_d = hset_n;
        vset_d = vset_n;
        ok_d   = ok_n;
        if (vs_rise) begin
            acc_d  = '0;
            hset_d = 1'b0;
            vset_d = 1'b0;
            ok_d   = 1'b1;
        end

        state_d  = state_q;
        lat_d    = lat_q;
        locked_d = locked_q;
        if (timeout) begin
            state_d  = ST_SEARCH;
            locked_d = 1'b0;
        end else if (vs_rise) begin
            case (state_q)
                ST_SEARCH: state_d = ST_MEASURE;
                ST_MEASURE: begin
                    lat_d   = acc_n;
                    state_d = ok_n ? ST_VERIFY : ST_MEASURE;
                end
                ST_VERIFY: begin
                    if (ok_n && match) begin
                        state_d  = ST_LOCKED;
                        locked_d = 1'b1;
                    end else begin
                        lat_d   = acc_n;
                        state_d = ST_MEASURE;
                    end
                end
                ST_LOCKED: begin
                    if (!(ok_n && match)) begin
                        lat_d    = acc_n;
                        locked_d = 1'b0;
                        state_d  = ST_VERIFY;
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            vis_q    <= 1'b0;
            vis_o_q  <= 1'b0;
            h_cnt_q  <= '0;
            run_q    <= '0;
            hpos_q   <= '0;
            vpos_q   <= '0;
            first_q  <= 1'b0;
            fs_q     <= 1'b0;
            acc_q    <= '0;
            hset_q   <= 1'b0;
            vset_q   <= 1'b0;
            ok_q     <= 1'b0;
            lat_q    <= '0;
            state_q  <= ST_SEARCH;
            locked_q <= 1'b0;
        end else begin
            vis_q    <= i_visible;
            vis_o_q  <= vis_q;
            h_cnt_q  <= h_cnt_d;
            run_q    <= run_d;
            hpos_q   <= hpos_d;
            vpos_q   <= vpos_d;
            first_q  <= first_d;
            fs_q     <= vs_rise;
            acc_q    <= acc_d;
            hset_q   <= hset_d;
            vset_q   <= vset_d;
            ok_q     <= ok_d;
            lat_q    <= lat_d;
            state_q  <= state_d;
            locked_q <= locked_d;
        end
    end

    assign o_hpos        = hpos_q;
    assign o_vpos        = vpos_q;
    assign o_visible     = vis_o_q;
    assign o_frame_start = fs_q;
    assign o_h_total     = lat_q.h_total;
    assign o_h_visible   = lat_q.h_visible;
    assign o_v_total     = lat_q.v_total;
    assign o_v_visible   = lat_q.v_visible;
    assign o_locked      = locked_q;

endmodule
